seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Adds a start/done handshake, configurable data width and pattern width, and iterative operations: pattern-match counting and shift-add multiply.
- Sits between the register file and the accumulator. The controller stalls the PC while busy is high.
- Single-cycle ops still complete with latency 1, so the existing datapath timing is preserved.

Parameters:
W, 8, operand/result width (>= 4)
PAT_W, 4, pattern width for MATCH (1 <= PAT_W <= W)
OP_W, 4, opcode width

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
start  input  1  request; accepted when busy=0
op  input  OP_W  operation select, sampled on accept
ci  input  1  carry in, sampled on accept
in_a  input  W  operand A, sampled on accept
in_b  input  W  operand B, sampled on accept
busy  output  1  high while a multi-cycle op is iterating
done  output  1  one-cycle pulse: rslt/co/z updated this cycle
rslt  output  W  registered result, held until next completion
co  output  1  registered carry/borrow/overflow flag
z  output  1  registered zero flag, equals (rslt==0)

Behaviour:
- Reset:
  - state=IDLE; busy, done, co, z = 0; rslt = 0.
  - Clears all internal operand, accumulator and counter registers.
  - Reset during RUN aborts the op: no done pulse, and no later result appears.
- FSM has two states, IDLE and RUN.
  - busy = (state==RUN).
  - done is registered and defaults to 0 every cycle.
- Accept: start=1 and state=IDLE at a rising edge. Operands are captured at that edge. start while busy=1 is ignored, not queued.
- Single-cycle ops, latency 1:
  - On the accept edge the result is computed from the inputs and registered, and done is set.
  - done is visible in the next cycle; state stays IDLE.
- Encodings:
  - 0 ADD: {co,rslt} = in_a + in_b + ci (W+1-bit sum).
  - 1 SUB: rslt = in_a - in_b (mod 2^W); co = 1 iff in_a < in_b unsigned (borrow).
  - 2 ABSD: signed |in_a - in_b|. rslt = larger minus smaller, computed in W+1 bits and truncated to W. co=0.
  - 3 MIN: unsigned minimum. co=0.
  - 4 MAX: unsigned maximum. co=0.
  - 7 PASSB: rslt = in_b. co=0.
  - 8..(2^OP_W-1) and undefined codes: rslt=0, co=0, z=1, latency 1.
- 5 MATCH, multi-cycle:
  - On accept: state→RUN, window index i=0, count=0.
  - Each RUN edge tests one window: count += (A[i+PAT_W-1:i] == B[PAT_W-1:0]), then i++.
  - After window i = W-PAT_W: rslt = count (zero-extended), co=0, done=1, state→IDLE.
  - Latency, accept edge to done visible = W-PAT_W+2 cycles (6 at defaults).
- 6 MUL, multi-cycle, unsigned shift-add:
  - Runs W RUN cycles. Each cycle: if B[0], acc += A<<k; B >>= 1; k++. The accumulator is 2W bits.
  - Completion: rslt = acc[W-1:0], co = |acc[2W-1:W] (overflow).
  - Latency = W+1 cycles (9 at defaults).
- z is always (new rslt == 0), updated only on a done edge.
- rslt, co and z are held unchanged between done pulses, including while busy.
- Back-to-back: start may be asserted in the cycle done is high, because state is IDLE then. It is accepted, and the next result follows with normal latency.
- Counters: i needs ceil(log2(W-PAT_W+2)) bits; k needs ceil(log2(W+1)) bits; count is sized to W. There is no wrap within a legal op.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles → rslt=0, co=0, z=0, busy=0, done=0. start held 0 → done never pulses.
- ADD: a=200, b=100, ci=1 → done 1 cycle after accept, rslt=45, co=1, z=0. SUB a=5, b=9 → rslt=252, co=1. ABSD a=0xF6 (-10), b=5 → rslt=15, co=0.
- MATCH: a=0xB6, b=0x06, defaults → busy high 5 cycles, done at cycle 6, rslt=2, z=0. a=0x00, b=0x0F → rslt=0, z=1.
- MUL: 15×17 → rslt=255, co=0, done at cycle 9. 16×16 → rslt=0, co=1, z=1.
- Handshake:
  - start pulsed with op=ADD while a MUL is busy → ignored; the MUL result is unchanged.
  - ADD asserted in the MUL done cycle → accepted; second done exactly 1 cycle later.
- Reset at cycle 4 of a MUL → busy=0 and outputs=0 next cycle, and no done pulse follows.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/done handshake.
// Single-cycle ops (ADD, SUB, ABSD, MIN, MAX, PASSB) complete on the accept edge.
// MATCH counts pattern hits across all windows of A, one window per cycle.
// MUL is an unsigned shift-add multiply that takes W iterations.
module seq_alu #(
  parameter int unsigned W     = 8,
  parameter int unsigned PAT_W = 4,
  parameter int unsigned OP_W  = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic            ci,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    rslt,
  output logic            co,
  output logic            z
);

  localparam int unsigned ACC_W  = 2 * W;
  localparam int unsigned I_W    = $clog2(W - PAT_W + 2);
  localparam int unsigned K_W    = $clog2(W + 1);
  localparam int unsigned I_LAST = W - PAT_W;
  localparam int unsigned K_LAST = W - 1;

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ABSD  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MIN   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MAX   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MATCH = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_PASSB = OP_W'(7);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [I_W-1:0]   i_q, i_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [W-1:0]     cnt_q, cnt_d;
  logic             is_mul_q, is_mul_d;
  logic [W-1:0]     rslt_q, rslt_d;
  logic             co_q, co_d;
  logic             z_q, z_d;
  logic             done_q, done_d;

  logic [W-1:0]     sc_rslt;
  logic             sc_co;
  logic [W:0]       sc_wide;
  logic             hit;
  logic [W-1:0]     cnt_nxt;
  logic [ACC_W-1:0] acc_nxt;

  // Single-cycle datapath: result and carry straight from the port operands.
  always_comb begin
    sc_rslt = '0;
    sc_co   = 1'b0;
    sc_wide = '0;
    case (op)
      OP_ADD: begin
        sc_wide = (W+1)'(in_a) + (W+1)'(in_b) + (W+1)'(ci);
        sc_rslt = sc_wide[W-1:0];
        sc_co   = sc_wide[W];
      end
      OP_SUB: begin
        sc_rslt = in_a - in_b;
        sc_co   = (in_a < in_b);
      end
      OP_ABSD: begin
        // Sign-extend to W+1 bits so the difference of any signed pair fits.
        if ($signed(in_a) > $signed(in_b)) begin
          sc_wide = {in_a[W-1], in_a} - {in_b[W-1], in_b};
        end else begin
          sc_wide = {in_b[W-1], in_b} - {in_a[W-1], in_a};
        end
        sc_rslt = sc_wide[W-1:0];
      end
      OP_MIN:   sc_rslt = (in_a < in_b) ? in_a : in_b;
      OP_MAX:   sc_rslt = (in_a > in_b) ? in_a : in_b;
      OP_PASSB: sc_rslt = in_b;
      default: begin
        sc_rslt = '0;
        sc_co   = 1'b0;
      end
    endcase
  end

  // One MATCH window test and one MUL partial-product step per RUN cycle.
  always_comb begin
    hit     = (PAT_W'(a_q >> i_q) == b_q[PAT_W-1:0]);
    cnt_nxt = cnt_q + W'(hit);
    acc_nxt = acc_q + (b_q[0] ? (ACC_W'(a_q) << k_q) : '0);
  end

  // Next-state and output logic for the IDLE/RUN controller.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    i_d      = i_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    rslt_d   = rslt_q;
    co_d     = co_q;
    z_d      = z_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_MATCH) begin
            a_d      = in_a;
            b_d      = in_b;
            i_d      = '0;
            cnt_d    = '0;
            is_mul_d = 1'b0;
            state_d  = RUN;
          end else if (op == OP_MUL) begin
            a_d      = in_a;
            b_d      = in_b;
            acc_d    = '0;
            k_d      = '0;
            is_mul_d = 1'b1;
            state_d  = RUN;
          end else begin
            rslt_d = sc_rslt;
            co_d   = sc_co;
            z_d    = (sc_rslt == '0);
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (is_mul_q) begin
          acc_d = acc_nxt;
          b_d   = b_q >> 1;
          if (k_q == K_W'(K_LAST)) begin
            rslt_d  = acc_nxt[W-1:0];
            co_d    = |acc_nxt[ACC_W-1:W];
            z_d     = (acc_nxt[W-1:0] == '0);
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end else begin
          cnt_d = cnt_nxt;
          if (i_q == I_W'(I_LAST)) begin
            rslt_d  = cnt_nxt;
            co_d    = 1'b0;
            z_d     = (cnt_nxt == '0);
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            i_d = i_q + I_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      rslt_q   <= '0;
      co_q     <= 1'b0;
      z_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
      rslt_q   <= rslt_d;
      co_q     <= co_d;
      z_q      <= z_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign rslt = rslt_q;
  assign co   = co_q;
  assign z    = z_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;

  localparam int unsigned W     = 8;
  localparam int unsigned PAT_W = 4;
  localparam int unsigned OP_W  = 4;
  localparam int MASK  = (1 << W) - 1;
  localparam int PMASK = (1 << PAT_W) - 1;
  localparam int MAX_WAIT = 64;

  logic            Clk;
  logic            Reset;
  logic            start;
  logic [OP_W-1:0] op;
  logic            ci;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic            busy;
  logic            done;
  logic [W-1:0]    rslt;
  logic            co;
  logic            z;

  int n_chk  = 0;
  int n_pass = 0;

  seq_alu #(.W(W), .PAT_W(PAT_W), .OP_W(OP_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .start (start),
    .op    (op),
    .ci    (ci),
    .in_a  (in_a),
    .in_b  (in_b),
    .busy  (busy),
    .done  (done),
    .rslt  (rslt),
    .co    (co),
    .z     (z)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: expected result, flag and accept-to-done latency from the op rules.
  function automatic void model(input int o, input int a, input int b, input int c,
                                output int r, output int f, output int lat);
    int s, sa, sb, cnt;
    longint p;
    r = 0; f = 0; lat = 1;
    case (o)
      0: begin s = a + b + c; r = s & MASK; f = (s >> W) & 1; end
      1: begin r = (a - b) & MASK; f = (a < b) ? 1 : 0; end
      2: begin
        sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        r = ((sa > sb) ? sa - sb : sb - sa) & MASK;
      end
      3: r = (a < b) ? a : b;
      4: r = (a > b) ? a : b;
      5: begin
        cnt = 0;
        for (int i = 0; i <= int'(W - PAT_W); i++)
          if (((a >> i) & PMASK) == (b & PMASK)) cnt++;
        r = cnt; lat = W - PAT_W + 2;
      end
      6: begin
        p = longint'(a) * longint'(b);
        r = int'(p) & MASK; f = ((p >> W) != 0) ? 1 : 0; lat = W + 1;
      end
      7: r = b;
      default: r = 0;
    endcase
  endfunction

  // Present one request on the next falling edge; returns after the accept edge (+1).
  task automatic issue(input int o, input int a, input int b, input int c);
    @(negedge Clk);
    start = 1'b1; op = OP_W'(o); in_a = W'(a); in_b = W'(b); ci = 1'(c);
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  // Count cycles until done, noting busy cycles and whether rslt stayed put meanwhile.
  task automatic wait_done(input int held, output int lat, output int bcyc, output int hold_ok);
    lat = 1; bcyc = 0; hold_ok = 1;
    while (!done && lat < MAX_WAIT) begin
      if (busy) bcyc++;
      if (int'(rslt) != held) hold_ok = 0;
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input int o, input int a, input int b, input int c, input string tag);
    int er, ef, el, lat, bcyc, hold_ok, prev;
    model(o, a, b, c, er, ef, el);
    prev = int'(rslt);
    issue(o, a, b, c);
    wait_done(prev, lat, bcyc, hold_ok);
    check({tag, " latency"}, lat, el);
    check({tag, " rslt"}, int'(rslt), er);
    check({tag, " co"}, int'(co), ef);
    check({tag, " z"}, int'(z), (er == 0) ? 1 : 0);
    check({tag, " busy_cycles"}, bcyc, el - 1);
    check({tag, " held"}, hold_ok, 1);
    @(posedge Clk); #1;
    check({tag, " done_pulse"}, int'(done), 0);
    check({tag, " after_hold"}, int'(rslt), er);
  endtask

  initial begin
    int er, ef, el, lat, bcyc, hold_ok, seen;
    Reset = 1'b1; start = 1'b0; op = '0; ci = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("reset rslt", int'(rslt), 0);
    check("reset co", int'(co), 0);
    check("reset z", int'(z), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    seen = 0;
    repeat (5) begin @(posedge Clk); #1; if (done) seen = 1; end
    check("idle no done", seen, 0);

    // Directed cases.
    run_op(0, 200, 100, 1, "add");
    run_op(1, 5, 9, 0, "sub");
    run_op(2, 'hF6, 5, 0, "absd");
    run_op(5, 'hB6, 'h06, 0, "match2");
    run_op(5, 'h00, 'h0F, 0, "match0");
    run_op(6, 15, 17, 0, "mul255");
    run_op(6, 16, 16, 0, "mulovf");
    run_op(3, 3, 200, 0, "min");
    run_op(4, 3, 200, 0, "max");
    run_op(7, 0, 77, 1, "passb");
    run_op(12, 99, 33, 1, "undef");

    // start while MUL busy is ignored.
    model(6, 13, 11, 0, er, ef, el);
    issue(6, 13, 11, 0);
    @(negedge Clk);
    start = 1'b1; op = OP_W'(0); in_a = W'(1); in_b = W'(1); ci = 1'b0;
    @(posedge Clk); #1;
    start = 1'b0;
    wait_done(int'(rslt), lat, bcyc, hold_ok);
    check("ignore latency", lat + 1, el);
    check("ignore rslt", int'(rslt), er);
    check("ignore co", int'(co), ef);

    // ADD asserted in the MUL done cycle is accepted back-to-back.
    issue(6, 7, 9, 0);
    wait_done(int'(rslt), lat, bcyc, hold_ok);
    check("b2b mul rslt", int'(rslt), 63);
    start = 1'b1; op = OP_W'(0); in_a = W'(40); in_b = W'(2); ci = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    check("b2b add done", int'(done), 1);
    check("b2b add rslt", int'(rslt), 43);
    check("b2b add busy", int'(busy), 0);

    // Reset mid-MUL aborts with no later result.
    issue(6, 255, 255, 0);
    repeat (3) @(posedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort rslt", int'(rslt), 0);
    check("abort co", int'(co), 0);
    check("abort z", int'(z), 0);
    check("abort done", int'(done), 0);
    seen = 0;
    repeat (15) begin @(posedge Clk); #1; if (done || rslt != '0) seen = 1; end
    check("abort quiet", seen, 0);

    // Randomized ops, biased toward defined codes.
    for (int n = 0; n < 150; n++) begin
      int o;
      o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 7));
      run_op(o, int'($urandom) & MASK, int'($urandom) & MASK, int'($urandom_range(0, 1)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
